button_conditioner: RTL and testbench

- Input-side counterpart to the LED/clock-divider output logic on the iCEBreaker: it turns raw, bouncing, asynchronous BTN pins into clean, CLK-synchronous events.
- Per button it provides: a debounced level, one-cycle press and release pulses, and a one-cycle long-press pulse.
- Sits between the top-level BTN pins and the user logic, which otherwise toggles LEDs on these events.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_channel.sv | 130 +++++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: clock-derived default cycle
// counts and the per-channel state encoding.
package btn_pkg;

  localparam int CLK_HZ      = 12_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int LONG_MS     = 1000;

  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int LONG_CYCLES_DEF     = (CLK_HZ / 1000) * LONG_MS;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARM_PRESS   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    ARM_RELEASE = 3'd4
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchronizer, polarity fix, debounce counter,
// hold counter and a small state tracker. All outputs are registered.
module btn_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 0,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 2);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  logic          sync1_q, sync2_q, sync_s;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  btn_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Synchronizer flops reset to the raw idle level so reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= POL;
      sync2_q   <= POL;
      stable_q  <= 1'b0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign sync_s = sync2_q ^ POL;

  always_comb begin
    stable_d  = stable_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (sync_s != stable_q) begin
      if (dcnt_q == D_LAST) begin
        stable_d  = sync_s;
        dcnt_d    = '0;
        press_d   = sync_s;
        release_d = ~sync_s;
      end else begin
        dcnt_d = dcnt_q + D_ONE;
      end
    end else begin
      dcnt_d = '0;
    end

    // Hold count starts after the press-pulse cycle and saturates once long fires.
    if (press_d || release_d || press_q || !stable_q) begin
      hcnt_d = '0;
    end else if (hcnt_q != H_LAST) begin
      hcnt_d = hcnt_q + H_ONE;
      long_d = (hcnt_q == H_PRE);
    end else begin
      hcnt_d = hcnt_q;
    end

    case (state_q)
      IDLE: begin
        if (sync_s) state_d = ARM_PRESS;
        else        state_d = IDLE;
      end
      ARM_PRESS: begin
        if (press_d)      state_d = HELD;
        else if (!sync_s) state_d = IDLE;
        else              state_d = ARM_PRESS;
      end
      HELD: begin
        if (!sync_s)     state_d = ARM_RELEASE;
        else if (long_d) state_d = LONG_HELD;
        else             state_d = HELD;
      end
      LONG_HELD: begin
        if (!sync_s) state_d = ARM_RELEASE;
        else         state_d = LONG_HELD;
      end
      ARM_RELEASE: begin
        if (release_d)              state_d = IDLE;
        else if (!sync_s)           state_d = ARM_RELEASE;
        else if (hcnt_d == H_LAST)  state_d = LONG_HELD;
        else                        state_d = HELD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pressed_o       = stable_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign long_pulse_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw button pins into clean debounced levels and
// press/release/long-press pulses, one independent channel per pin.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int ACTIVE_LOW      = 0,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] BTN,
  output logic [NUM_BTN-1:0] PRESSED,
  output logic [NUM_BTN-1:0] PRESS_PULSE,
  output logic [NUM_BTN-1:0] RELEASE_PULSE,
  output logic [NUM_BTN-1:0] LONG_PULSE
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_chan (
      .clk_i           (CLK),
      .rst_i           (RST),
      .btn_i           (BTN[g]),
      .pressed_o       (PRESSED[g]),
      .press_pulse_o   (PRESS_PULSE[g]),
      .release_pulse_o (RELEASE_PULSE[g]),
      .long_pulse_o    (LONG_PULSE[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long counts,
// covering both pin polarities with one instance each.
module tb_button_conditioner;

  localparam int N  = 3;
  localparam int DC = 4;
  localparam int LC = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn, btn_n;
  logic [N-1:0] pressed, press_p, rel_p, long_p;
  logic [N-1:0] pressed_n, press_p_n, rel_p_n, long_p_n;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt [N];
  int rel_cnt   [N];
  int long_cnt  [N];
  int press_n_cnt, rel_n_cnt, long_n_cnt;

  button_conditioner #(
    .NUM_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)
  ) dut (
    .CLK(clk), .RST(rst), .BTN(btn), .PRESSED(pressed),
    .PRESS_PULSE(press_p), .RELEASE_PULSE(rel_p), .LONG_PULSE(long_p)
  );

  button_conditioner #(
    .NUM_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)
  ) dut_n (
    .CLK(clk), .RST(rst), .BTN(btn_n), .PRESSED(pressed_n),
    .PRESS_PULSE(press_p_n), .RELEASE_PULSE(rel_p_n), .LONG_PULSE(long_p_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0;
      rel_cnt[c]   = 0;
      long_cnt[c]  = 0;
    end
    press_n_cnt = 0;
    rel_n_cnt   = 0;
    long_n_cnt  = 0;
  endtask

  // Advance n edges, sampling 1 time unit after each edge and tallying pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        press_cnt[c] += int'(press_p[c]);
        rel_cnt[c]   += int'(rel_p[c]);
        long_cnt[c]  += int'(long_p[c]);
      end
      press_n_cnt += $countones(press_p_n);
      rel_n_cnt   += $countones(rel_p_n);
      long_n_cnt  += $countones(long_p_n);
    end
  endtask

  initial begin
    rst   = 1'b1;
    btn   = 3'b000;
    btn_n = 3'b111;
    clear_counts();
    tick(3);
    check_eq("rst_pressed", 32'(pressed), 32'h0);
    check_eq("rst_press",   32'(press_p), 32'h0);
    check_eq("rst_release", 32'(rel_p),   32'h0);
    check_eq("rst_long",    32'(long_p),  32'h0);
    check_eq("rst_n_all",   32'({pressed_n, press_p_n, rel_p_n, long_p_n}), 32'h0);
    rst = 1'b0;
    clear_counts();
    tick(20);
    check_eq("n_idle_no_pulse", 32'(press_n_cnt + rel_n_cnt + long_n_cnt), 32'd0);
    check_eq("n_idle_pressed",  32'(pressed_n), 32'h0);

    // Clean press and long hold on channel 0
    clear_counts();
    btn = 3'b001;
    tick(5);
    check_eq("clean_early_press", 32'(press_p), 32'h0);
    check_eq("clean_early_level", 32'(pressed), 32'h0);
    tick(1);
    check_eq("clean_press",       32'(press_p), 32'b001);
    check_eq("clean_level",       32'(pressed), 32'b001);
    tick(9);
    check_eq("long_early",        32'(long_p),  32'h0);
    tick(1);
    check_eq("long_fire",         32'(long_p),  32'b001);
    check_eq("long_not_press",    32'(press_p), 32'h0);
    tick(50);
    check_eq("long_once",         32'(long_cnt[0]),  32'd1);
    check_eq("press_once",        32'(press_cnt[0]), 32'd1);
    btn = 3'b000;
    tick(6);
    check_eq("clean_release",     32'(rel_p),   32'b001);
    check_eq("clean_rel_level",   32'(pressed), 32'h0);
    tick(5);

    // Bounce on channel 1
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      btn[1] = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick(2);
    end
    btn[1] = 1'b1;
    tick(5);
    check_eq("bounce_quiet",      32'(press_cnt[1] + rel_cnt[1]), 32'd0);
    tick(1);
    check_eq("bounce_press",      32'(press_p), 32'b010);
    tick(10);
    check_eq("bounce_press_once", 32'(press_cnt[1]), 32'd1);
    btn[1] = 1'b0;
    tick(20);

    // Short tap on channel 2
    clear_counts();
    btn[2] = 1'b1;
    tick(6);
    check_eq("tap_press",         32'(press_p), 32'b100);
    btn[2] = 1'b0;
    tick(5);
    check_eq("tap_rel_early",     32'(rel_p),   32'h0);
    tick(1);
    check_eq("tap_release",       32'(rel_p),   32'b100);
    check_eq("tap_level",         32'(pressed), 32'h0);
    tick(20);
    check_eq("tap_no_long",       32'(long_cnt[2]), 32'd0);
    check_eq("tap_counts",        32'({press_cnt[2][7:0], rel_cnt[2][7:0]}), 32'h0101);

    // Simultaneous press, then partial release
    clear_counts();
    btn = 3'b111;
    tick(6);
    check_eq("sim_press",         32'(press_p), 32'b111);
    check_eq("sim_level",         32'(pressed), 32'b111);
    btn = 3'b110;
    tick(6);
    check_eq("sim_release",       32'(rel_p),   32'b001);
    check_eq("sim_rel_no_press",  32'(press_p), 32'h0);
    check_eq("sim_rel_level",     32'(pressed), 32'b110);
    btn = 3'b000;
    tick(25);

    // Reset in mid-debounce with the button held through it
    clear_counts();
    btn = 3'b001;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("midrst_outputs",    32'({pressed, press_p, rel_p, long_p}), 32'h0);
    tick(1);
    check_eq("midrst_deadline",   32'(press_p), 32'h0);
    tick(4);
    check_eq("midrst_early",      32'(press_p), 32'h0);
    tick(1);
    check_eq("midrst_press",      32'(press_p), 32'b001);
    btn = 3'b000;
    tick(20);

    // Active-low instance: same timing as the clean press
    clear_counts();
    btn_n = 3'b110;
    tick(5);
    check_eq("n_press_early",     32'(press_p_n), 32'h0);
    tick(1);
    check_eq("n_press",           32'(press_p_n), 32'b001);
    check_eq("n_level",           32'(pressed_n), 32'b001);
    tick(9);
    check_eq("n_long_early",      32'(long_p_n),  32'h0);
    tick(1);
    check_eq("n_long",            32'(long_p_n),  32'b001);
    btn_n = 3'b111;
    tick(6);
    check_eq("n_release",         32'(rel_p_n),   32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
